atm_txn_arbiter: RTL and testbench
==================================

Name: atm_txn_arbiter

Overview:
- Shares the single account-balance register among three transaction requesters: withdraw, deposit and transfer.
- Arbitrates them round-robin, runs one check-and-update sequence per grant, and returns a status over a 4-phase req/done handshake.
- Sits between the ATM menu FSM (whose withdraw, deposit and transfer states drive the requests) and the balance storage. It owns the balance register.

Parameters:
- AMT_W, 32, width of amounts and of the balance
- ACCT_W, 16, width of the account number
- INIT_BALANCE, 32'h000186A0, balance loaded on reset (100000)
- DEST_ACCT, 16'hD903, only valid transfer destination account

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- lock  in  1  card locked/ejected; blocks new grants
- wd_req  in  1  withdraw request
- wd_amount  in  AMT_W  withdraw amount; held while wd_req=1
- dep_req  in  1  deposit request
- dep_amount  in  AMT_W  deposit amount; held while dep_req=1
- xfer_req  in  1  transfer request
- xfer_amount  in  AMT_W  transfer amount; held while xfer_req=1
- xfer_acct  in  ACCT_W  transfer destination account; held while xfer_req=1
- grant  out  3  one-hot grant {xfer,dep,wd}; 0 when idle
- done  out  1  transaction complete; held until granted req drops
- ok  out  1  valid only with done; 1 = balance updated
- err_code  out  2  valid only with done: 00 ok, 01 insufficient funds, 10 bad account, 11 zero amount/overflow
- balance  out  AMT_W  current balance register
- busy  out  1  state != IDLE

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE, balance=INIT_BALANCE, grant=0, done=0, ok=0, err_code=00.
  - Round-robin pointer set so wd has highest priority.
  - An in-flight transaction is discarded; a reset during COMMIT leaves balance=INIT_BALANCE.
- States: IDLE -> CHECK -> COMMIT -> RESP -> IDLE. All outputs are registered.
- IDLE:
  - If lock=0 and any req=1: pick a requester by round-robin (priority order starting at the pointer: wd, dep, xfer, wrapping), latch its amount and account, set grant, go to CHECK.
  - Pointer moves to the requester after the one granted (xfer wraps to wd).
  - If lock=1: no grant, stay in IDLE. lock has no effect in the other states; an in-flight transaction completes.
- CHECK: compute status from the latched values and the current balance. Checks in order, first failure wins:
  - Any type: amount==0 -> 11.
  - Transfer: xfer_acct!=DEST_ACCT -> 10.
  - Withdraw or transfer: amount>balance -> 01. amount==balance is legal and leaves balance 0.
  - Deposit: balance+amount computed AMT_W+1 wide; carry out -> 11. balance is never wrapped.
- COMMIT:
  - If status==00: withdraw and transfer subtract the amount; deposit adds it. The new balance is visible the next cycle.
  - Otherwise balance is unchanged.
- RESP:
  - done=1, ok=(status==00), err_code=status; grant held.
  - Stay while the granted req=1. When it is 0, next cycle go to IDLE with grant=0, done=0, ok=0, err_code=00.
  - If the req drops early (during CHECK or COMMIT), the transaction still completes and RESP lasts exactly one cycle.
- Latency: req sampled in IDLE at edge N -> grant=1 after N -> done=1 after edge N+3. Minimum 5 cycles from req to the next grant.
- Requests for ungranted requesters are ignored while busy and stay pending. At most one grant is active at a time; grant is always one-hot or 0.
- Simultaneous requests: each is served once in rotation; no requester is starved.

Test Plan:
- Reset, then wd_req=1 with wd_amount=1000 -> grant=001 one cycle later, done=1/ok=1/err=00 three cycles after the grant, balance=99000. Drop wd_req -> idle next cycle.
- wd_req, dep_req, xfer_req held simultaneously (valid values, xfer_acct=16'hD903) -> grants in order 001, 010, 100; then wd again first if re-raised.
- wd_amount=100001 with balance=100000 -> err_code=01, ok=0, balance unchanged. wd_amount=100000 -> ok=1, balance=0.
- xfer_acct=16'h1234, xfer_amount=5 -> err_code=10. Deposit 32'hFFFFFFFF at balance 100000 -> err_code=11, balance unchanged. Zero amount -> err_code=11.
- lock=1 with dep_req=1 -> no grant for 10 cycles. lock rises during COMMIT -> transaction completes normally.
- Assert reset_n=0 during COMMIT of a 500 deposit -> all outputs 0 immediately, balance=100000 after release, no done pulse.

Source files
------------

// File: rtl/atm_txn_arbiter.sv
// atm_txn_arbiter: round-robin arbiter that gives withdraw, deposit and
// transfer requesters exclusive access to the account balance register.
// Each grant runs CHECK -> COMMIT -> RESP and answers over a 4-phase
// req/done handshake. All outputs come straight from flops.
module atm_txn_arbiter #(
  parameter int                AMT_W        = 32,
  parameter int                ACCT_W       = 16,
  parameter logic [AMT_W-1:0]  INIT_BALANCE = 32'h000186A0,
  parameter logic [ACCT_W-1:0] DEST_ACCT    = 16'hD903
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              lock,
  input  logic              wd_req,
  input  logic [AMT_W-1:0]  wd_amount,
  input  logic              dep_req,
  input  logic [AMT_W-1:0]  dep_amount,
  input  logic              xfer_req,
  input  logic [AMT_W-1:0]  xfer_amount,
  input  logic [ACCT_W-1:0] xfer_acct,
  output logic [2:0]        grant,
  output logic              done,
  output logic              ok,
  output logic [1:0]        err_code,
  output logic [AMT_W-1:0]  balance,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CHECK  = 2'd1,
    S_COMMIT = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  // Requester indices; also the bit positions inside grant.
  localparam logic [1:0] WD   = 2'd0;
  localparam logic [1:0] DEP  = 2'd1;
  localparam logic [1:0] XFER = 2'd2;

  localparam logic [1:0] ST_OK    = 2'b00;
  localparam logic [1:0] ST_FUNDS = 2'b01;
  localparam logic [1:0] ST_ACCT  = 2'b10;
  localparam logic [1:0] ST_RANGE = 2'b11;

  state_t              state_q, state_d;
  logic [2:0]          grant_q, grant_d;
  logic                done_q, done_d;
  logic                ok_q, ok_d;
  logic [1:0]          err_q, err_d;
  logic [AMT_W-1:0]    balance_q, balance_d;
  logic                busy_q, busy_d;
  logic [1:0]          ptr_q, ptr_d;
  logic [1:0]          who_q, who_d;
  logic [AMT_W-1:0]    amt_q, amt_d;
  logic [ACCT_W-1:0]   acct_q, acct_d;
  logic [1:0]          status_q, status_d;

  logic [2:0]          req_vec;
  logic [1:0]          c1, c2, pick;
  logic [AMT_W-1:0]    pick_amt;
  logic [AMT_W:0]      dep_sum;

  // Next requester in rotation order wd -> dep -> xfer -> wd.
  function automatic logic [1:0] rr_next(input logic [1:0] i);
    return (i == XFER) ? WD : i + 2'd1;
  endfunction

  // First failing check wins: zero amount, bad account, funds, overflow.
  function automatic logic [1:0] check_status(
    input logic [1:0]        who,
    input logic [AMT_W-1:0]  amt,
    input logic [AMT_W-1:0]  bal,
    input logic [ACCT_W-1:0] acct,
    input logic              dep_carry
  );
    if (amt == '0)                           return ST_RANGE;
    if (who == XFER && acct != DEST_ACCT)    return ST_ACCT;
    if (who != DEP && amt > bal)             return ST_FUNDS;
    if (who == DEP && dep_carry)             return ST_RANGE;
    return ST_OK;
  endfunction

  assign req_vec = {xfer_req, dep_req, wd_req};
  assign dep_sum = {1'b0, balance_q} + {1'b0, amt_q};

  // Round-robin choice starting at the pointer, plus the chosen amount.
  always_comb begin
    c1 = rr_next(ptr_q);
    c2 = rr_next(c1);
    if (req_vec[ptr_q])   pick = ptr_q;
    else if (req_vec[c1]) pick = c1;
    else                  pick = c2;
    case (pick)
      WD:      pick_amt = wd_amount;
      DEP:     pick_amt = dep_amount;
      default: pick_amt = xfer_amount;
    endcase
  end

  // Transaction sequencer: grant, check, commit, then hold the response.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    done_d    = done_q;
    ok_d      = ok_q;
    err_d     = err_q;
    balance_d = balance_q;
    busy_d    = busy_q;
    ptr_d     = ptr_q;
    who_d     = who_q;
    amt_d     = amt_q;
    acct_d    = acct_q;
    status_d  = status_q;
    case (state_q)
      S_IDLE: begin
        if (!lock && (req_vec != 3'b000)) begin
          grant_d = 3'b001 << pick;
          who_d   = pick;
          amt_d   = pick_amt;
          acct_d  = xfer_acct;
          ptr_d   = rr_next(pick);
          busy_d  = 1'b1;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        status_d = check_status(who_q, amt_q, balance_q, acct_q, dep_sum[AMT_W]);
        state_d  = S_COMMIT;
      end
      S_COMMIT: begin
        if (status_q == ST_OK) begin
          balance_d = (who_q == DEP) ? dep_sum[AMT_W-1:0] : balance_q - amt_q;
        end
        state_d = S_RESP;
      end
      default: begin
        // First RESP cycle raises done regardless of req, so an early
        // drop still yields exactly one done cycle.
        if (!done_q) begin
          done_d = 1'b1;
          ok_d   = (status_q == ST_OK);
          err_d  = status_q;
        end else if (!req_vec[who_q]) begin
          grant_d = 3'b000;
          done_d  = 1'b0;
          ok_d    = 1'b0;
          err_d   = ST_OK;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
    endcase
  end

  // State and output registers; reset discards any in-flight transaction.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      grant_q   <= 3'b000;
      done_q    <= 1'b0;
      ok_q      <= 1'b0;
      err_q     <= ST_OK;
      balance_q <= INIT_BALANCE;
      busy_q    <= 1'b0;
      ptr_q     <= WD;
      who_q     <= WD;
      amt_q     <= '0;
      acct_q    <= '0;
      status_q  <= ST_OK;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      done_q    <= done_d;
      ok_q      <= ok_d;
      err_q     <= err_d;
      balance_q <= balance_d;
      busy_q    <= busy_d;
      ptr_q     <= ptr_d;
      who_q     <= who_d;
      amt_q     <= amt_d;
      acct_q    <= acct_d;
      status_q  <= status_d;
    end
  end

  assign grant    = grant_q;
  assign done     = done_q;
  assign ok       = ok_q;
  assign err_code = err_q;
  assign balance  = balance_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_atm_txn_arbiter.sv
// Bench for atm_txn_arbiter: a transaction-timeline model predicts every
// output each cycle; directed scenarios add literal expectations, then
// randomized requester traffic runs against the same model.
module tb_atm_txn_arbiter;

  localparam logic [31:0] INIT = 32'd100000;
  localparam logic [15:0] DEST = 16'hD903;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        lock = 1'b0;
  logic        wd_req = 1'b0, dep_req = 1'b0, xfer_req = 1'b0;
  logic [31:0] wd_amount = '0, dep_amount = '0, xfer_amount = '0;
  logic [15:0] xfer_acct = '0;
  logic [2:0]  grant;
  logic        done, ok, busy;
  logic [1:0]  err_code;
  logic [31:0] balance;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  atm_txn_arbiter dut (
    .clk(clk), .reset_n(reset_n), .lock(lock),
    .wd_req(wd_req), .wd_amount(wd_amount),
    .dep_req(dep_req), .dep_amount(dep_amount),
    .xfer_req(xfer_req), .xfer_amount(xfer_amount), .xfer_acct(xfer_acct),
    .grant(grant), .done(done), .ok(ok), .err_code(err_code),
    .balance(balance), .busy(busy)
  );

  // ---------------- behavioural model ----------------
  // A transaction is described by who was granted, how many edges ago,
  // its precomputed status and resulting balance.
  bit          m_active = 1'b0;
  int          m_who = 0;
  int          m_age = 0;
  int          m_ptr = 0;
  logic [31:0] m_bal = INIT;
  logic [31:0] m_newbal = '0;
  logic [1:0]  m_status = 2'b00;
  logic [2:0]  m_r;
  int          m_pick;
  logic [31:0] m_amt;

  function automatic logic [1:0] spec_status(input int who, input logic [31:0] amt,
                                             input logic [31:0] bal, input logic [15:0] acct);
    longint s;
    if (amt == 0) return 2'b11;
    if (who == 2 && acct != DEST) return 2'b10;
    if (who != 1 && amt > bal) return 2'b01;
    s = longint'(bal) + longint'(amt);
    if (who == 1 && s > 64'h0000_0000_FFFF_FFFF) return 2'b11;
    return 2'b00;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_active = 1'b0; m_ptr = 0; m_bal = INIT; m_age = 0; m_status = 2'b00;
    end else begin
      m_r = {xfer_req, dep_req, wd_req};
      if (!m_active) begin
        if (!lock && m_r != 3'b000) begin
          m_pick = -1;
          for (int k = 0; k < 3; k++)
            if (m_pick < 0 && m_r[(m_ptr + k) % 3]) m_pick = (m_ptr + k) % 3;
          m_amt = (m_pick == 0) ? wd_amount : (m_pick == 1) ? dep_amount : xfer_amount;
          m_status = spec_status(m_pick, m_amt, m_bal, xfer_acct);
          m_newbal = (m_pick == 1) ? m_bal + m_amt : m_bal - m_amt;
          m_who = m_pick; m_age = 0; m_active = 1'b1;
          m_ptr = (m_pick + 1) % 3;
        end
      end else if (m_age >= 3 && !m_r[m_who]) begin
        m_active = 1'b0;
      end else begin
        m_age++;
        if (m_age == 2 && m_status == 2'b00) m_bal = m_newbal;
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    logic [2:0] e_grant;
    logic       e_done, e_ok;
    logic [1:0] e_err;
    if (chk_en) begin
      e_grant = m_active ? (3'b001 << m_who) : 3'b000;
      e_done  = m_active && m_age >= 3;
      e_ok    = e_done && m_status == 2'b00;
      e_err   = e_done ? m_status : 2'b00;
      vectors++;
      if (grant !== e_grant || done !== e_done || ok !== e_ok || err_code !== e_err ||
          balance !== m_bal || busy !== m_active) begin
        miscompares++;
        $display("FAIL model t=%0t got g=%b d=%b ok=%b e=%b bal=%0d busy=%b want g=%b d=%b ok=%b e=%b bal=%0d busy=%b",
                 $time, grant, done, ok, err_code, balance, busy,
                 e_grant, e_done, e_ok, e_err, m_bal, m_active);
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic drive_req(input int who, input bit v);
    case (who)
      0: wd_req = v;
      1: dep_req = v;
      default: xfer_req = v;
    endcase
  endtask

  task automatic drive_amt(input int who, input logic [31:0] a, input logic [15:0] acct);
    case (who)
      0: wd_amount = a;
      1: dep_amount = a;
      default: begin xfer_amount = a; xfer_acct = acct; end
    endcase
  endtask

  function automatic bit req_of(input int who);
    return (who == 0) ? wd_req : (who == 1) ? dep_req : xfer_req;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    #2 reset_n = 1'b0;
    wd_req = 0; dep_req = 0; xfer_req = 0; lock = 0;
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 20) begin @(negedge clk); n++; end
    check("done_seen", done, 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 10) begin @(negedge clk); n++; end
    check("idle_reached", busy, 0);
  endtask

  task automatic run_txn(input int who, input logic [31:0] amt, input logic [15:0] acct,
                         output bit o, output logic [1:0] e, output logic [31:0] bal);
    @(negedge clk);
    drive_amt(who, amt, acct);
    drive_req(who, 1'b1);
    wait_done();
    o = ok; e = err_code; bal = balance;
    drive_req(who, 1'b0);
    @(negedge clk);
    wait_idle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    bit          o;
    logic [1:0]  e;
    logic [31:0] b;
    logic [2:0]  order [3];
    int          n;

    #1 reset_n = 1'b0;
    #1;
    check("rst_grant", grant, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_balance", balance, INIT);
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b1;
    @(negedge clk);
    chk_en = 1'b1;

    // Withdraw 1000 with explicit latency checks.
    @(negedge clk);
    wd_amount = 32'd1000; wd_req = 1'b1;
    @(negedge clk);
    check("t1_grant", grant, 3'b001);
    check("t1_done_early", done, 0);
    repeat (2) @(negedge clk);
    check("t1_done_n2", done, 0);
    @(negedge clk);
    check("t1_done", done, 1);
    check("t1_ok", ok, 1);
    check("t1_err", err_code, 0);
    check("t1_bal", balance, 32'd99000);
    wd_req = 1'b0;
    @(negedge clk);
    check("t1_grant_idle", grant, 0);
    check("t1_busy_idle", busy, 0);

    // Funds boundary.
    do_reset();
    run_txn(0, 32'd100001, DEST, o, e, b);
    check("funds_err", e, 2'b01); check("funds_ok", o, 0); check("funds_bal", b, INIT);
    run_txn(0, 32'd100000, DEST, o, e, b);
    check("exact_ok", o, 1); check("exact_err", e, 0); check("exact_bal", b, 0);
    run_txn(2, 32'd5, 16'h1234, o, e, b);
    check("acct_err", e, 2'b10); check("acct_ok", o, 0);

    // Overflow and zero amount.
    do_reset();
    run_txn(1, 32'hFFFF_FFFF, DEST, o, e, b);
    check("ovf_err", e, 2'b11); check("ovf_bal", b, INIT);
    run_txn(0, 32'd0, DEST, o, e, b);
    check("zero_err", e, 2'b11); check("zero_bal", b, INIT);

    // Simultaneous requests rotate wd, dep, xfer.
    do_reset();
    @(negedge clk);
    wd_amount = 32'd10; dep_amount = 32'd20; xfer_amount = 32'd30; xfer_acct = DEST;
    wd_req = 1; dep_req = 1; xfer_req = 1;
    for (int i = 0; i < 3; i++) begin
      wait_done();
      order[i] = grant;
      if (grant[0]) wd_req = 0;
      if (grant[1]) dep_req = 0;
      if (grant[2]) xfer_req = 0;
      @(negedge clk);
      wait_idle();
    end
    check("rr_first", order[0], 3'b001);
    check("rr_second", order[1], 3'b010);
    check("rr_third", order[2], 3'b100);
    wd_req = 1; dep_req = 1; xfer_req = 1;
    n = 0;
    while (grant == 3'b000 && n < 10) begin @(negedge clk); n++; end
    check("rr_wrap", grant, 3'b001);
    wd_req = 0; dep_req = 0; xfer_req = 0;
    @(negedge clk);
    wait_idle();

    // lock blocks grants; lock during COMMIT does not.
    do_reset();
    @(negedge clk);
    lock = 1; dep_amount = 32'd7; dep_req = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("lock_nogrant", grant, 0);
    end
    lock = 0;
    @(negedge clk);
    check("unlock_grant", grant, 3'b010);
    wait_done();
    dep_req = 0;
    @(negedge clk);
    wait_idle();
    @(negedge clk);
    wd_amount = 32'd50; wd_req = 1;
    repeat (2) @(negedge clk);
    lock = 1;
    wait_done();
    check("lockc_ok", ok, 1);
    check("lockc_bal", balance, 32'd99957);
    wd_req = 0;
    @(negedge clk);
    wait_idle();
    lock = 0;

    // Reset during COMMIT of a 500 deposit.
    do_reset();
    @(negedge clk);
    dep_amount = 32'd500; dep_req = 1;
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("rstc_grant", grant, 0);
    check("rstc_done", done, 0);
    check("rstc_ok", ok, 0);
    check("rstc_err", err_code, 0);
    check("rstc_busy", busy, 0);
    check("rstc_bal", balance, INIT);
    dep_req = 0;
    @(negedge clk);
    #2 reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("rstc_nodone", done, 0);
    end
    check("rstc_bal_after", balance, INIT);

    // Randomized requester traffic.
    do_reset();
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      if ($urandom_range(0, 19) == 0) lock = ~lock;
      for (int i = 0; i < 3; i++) begin
        if (!req_of(i) && !grant[i]) begin
          if ($urandom_range(0, 3) == 0) begin
            logic [31:0] a;
            logic [15:0] ac;
            case ($urandom_range(0, 9))
              0: a = 32'd0;
              1: a = 32'hFFFF_FFFF;
              2: a = balance;
              3: a = balance + 32'd1;
              default: a = $urandom_range(1, 60000);
            endcase
            ac = ($urandom_range(0, 4) == 0) ? 16'($urandom) : DEST;
            drive_amt(i, a, ac);
            drive_req(i, 1'b1);
          end
        end else if (req_of(i) && grant[i] && done) begin
          if ($urandom_range(0, 1) == 1) drive_req(i, 1'b0);
        end else if (req_of(i) && grant[i] && !done) begin
          if ($urandom_range(0, 15) == 0) drive_req(i, 1'b0);
        end
      end
    end
    lock = 0; wd_req = 0; dep_req = 0; xfer_req = 0;
    repeat (10) @(negedge clk);
    check("final_idle", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
